// File: rtl/decimator.sv
// Streaming decimate-by-2 FIR: buffers a frame of DELAY_SIZE samples, then produces
// ARRAY_SIZE outputs (one per cycle) using history carried over from the previous frame.
module decimator #(
    parameter int DELAY_SIZE = 32,
    parameter int TAP_SIZE   = 16,
    parameter int ARRAY_SIZE = 16,
    parameter int FRAC_BITS  = 8,
    parameter logic signed [31:0] COEFFS [TAP_SIZE] = '{default: 32'sd16}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [31:0]  new_sample,
    input  logic                valid_in,
    output logic signed [66:0]  decimated_output [0:ARRAY_SIZE-1],
    output logic                output_valid,
    output logic                WAIT
);

    localparam int CW = $clog2(DELAY_SIZE);
    localparam int KW = $clog2(ARRAY_SIZE);
    localparam int HN = TAP_SIZE - 1;
    localparam int HW = $clog2(HN);

    typedef enum logic [1:0] {COLLECT, COMPUTE, DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q;
    logic [KW-1:0]         k_q;
    logic signed [31:0]    frame_q [DELAY_SIZE];
    // hist_q[m] holds x[-1-m] of the current frame, i.e. the tail of the previous one
    logic signed [31:0]    hist_q  [HN];
    logic signed [66:0]    res_q   [ARRAY_SIZE];
    logic signed [66:0]    out_q   [ARRAY_SIZE];

    logic signed [67:0]    acc;
    logic signed [31:0]    s;
    logic signed [63:0]    p;
    int                    idx;
    logic                  unused_acc_msb;

    always_ff @(posedge clk) begin
        if (rst) state_q <= COLLECT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        output_valid = 1'b0;
        WAIT         = 1'b1;
        case (state_q)
            COLLECT: begin
                WAIT = 1'b0;
                if (valid_in && cnt_q == CW'(DELAY_SIZE - 1)) state_d = COMPUTE;
            end
            COMPUTE: if (k_q == KW'(ARRAY_SIZE - 1)) state_d = DONE;
            DONE: begin
                output_valid = 1'b1;
                state_d      = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    // One output per cycle: all TAP_SIZE products for index 2k summed in parallel
    always_comb begin
        acc = '0;
        s   = '0;
        p   = '0;
        idx = 0;
        for (int j = 0; j < TAP_SIZE; j++) begin
            idx = 2 * int'(k_q) - j;
            if (idx >= 0) s = frame_q[CW'(idx)];
            else          s = hist_q[HW'(-1 - idx)];
            p   = 64'(s) * 64'(COEFFS[j]);
            acc = acc + 68'(p >>> FRAC_BITS);
        end
    end

    assign unused_acc_msb = acc[67];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            k_q   <= '0;
            for (int i = 0; i < DELAY_SIZE; i++) frame_q[i] <= '0;
            for (int i = 0; i < HN; i++)         hist_q[i]  <= '0;
            for (int i = 0; i < ARRAY_SIZE; i++) out_q[i]   <= '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    k_q <= '0;
                    if (valid_in) begin
                        frame_q[cnt_q] <= new_sample;
                        cnt_q <= (cnt_q == CW'(DELAY_SIZE - 1)) ? '0 : cnt_q + 1'b1;
                    end
                end
                COMPUTE: begin
                    k_q <= k_q + 1'b1;
                    // Publish the whole frame at once so outputs are stable during DONE
                    if (k_q == KW'(ARRAY_SIZE - 1)) begin
                        for (int i = 0; i < ARRAY_SIZE - 1; i++) out_q[i] <= res_q[i];
                        out_q[ARRAY_SIZE-1] <= acc[66:0];
                    end
                end
                DONE: begin
                    for (int m = 0; m < HN; m++) hist_q[m] <= frame_q[DELAY_SIZE-1-m];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == COMPUTE) res_q[k_q] <= acc[66:0];
    end

    assign decimated_output = out_q;

endmodule

// File: tb/tb_decimator.sv
// Directed, table-driven bench for the decimate-by-2 FIR frame engine.
module tb_decimator;

    localparam int NV = 8;
    localparam int AS = 16;

    logic                clk;
    logic                rst;
    logic signed [31:0]  new_sample;
    logic                valid_in;
    logic signed [66:0]  dout [0:AS-1];
    logic                output_valid;
    logic                WAIT;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit                 do_reset;
        bit                 gap;
        bit                 pulse;
        logic signed [31:0] first;
        logic signed [31:0] rest;
    } vec_t;

    vec_t   vt     [NV];
    longint exp_tab[NV][AS];

    decimator dut (
        .clk              (clk),
        .rst              (rst),
        .new_sample       (new_sample),
        .valid_in         (valid_in),
        .decimated_output (dout),
        .output_valid     (output_valid),
        .WAIT             (WAIT)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [66:0] act,
                       input logic signed [66:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint ramp(input int k);
        return (2 * k + 1 < 16) ? longint'(2 * k + 1) : 64'sd16;
    endfunction

    task automatic run_frame(input int n);
        int lat;
        if (vt[n].do_reset) begin
            rst = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
        end
        for (int i = 0; i < 32; i++) begin
            if (vt[n].gap && (i % 3 == 1)) begin
                valid_in = 1'b0;
                @(negedge clk);
            end
            new_sample = (i == 0) ? vt[n].first : vt[n].rest;
            valid_in   = 1'b1;
            @(negedge clk);
        end
        valid_in = 1'b0;
        chk($sformatf("wait_compute v%0d", n), WAIT, 1);
        lat = 0;
        while (!output_valid && lat < 40) begin
            if (vt[n].pulse && (lat % 2 == 0)) begin
                valid_in   = 1'b1;
                new_sample = 32'sh0012_3456;
            end else begin
                valid_in = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        // DONE is seen 16 negedges after the acceptance edge: 17 cycles after the accept cycle
        chk($sformatf("latency v%0d", n), lat, 16);
        chk($sformatf("wait_done v%0d", n), WAIT, 1);
        for (int k = 0; k < AS; k++)
            chk($sformatf("y[%0d] v%0d", k, n), dout[k], exp_tab[n][k]);
        valid_in   = vt[n].pulse;
        new_sample = 32'sh0065_4321;
        @(negedge clk);
        valid_in = 1'b0;
        chk($sformatf("ov_low v%0d", n), output_valid, 0);
        chk($sformatf("wait_low v%0d", n), WAIT, 0);
        @(negedge clk);
        chk($sformatf("hold y15 v%0d", n), dout[AS-1], exp_tab[n][AS-1]);
    endtask

    initial begin
        int ov_hits;
        clk = 1'b0; rst = 1'b1; valid_in = 1'b0; new_sample = '0;

        vt[0] = '{1'b1, 1'b0, 1'b0, 32'sd256, 32'sd256};   // DC step from reset
        vt[1] = '{1'b0, 1'b1, 1'b0, 32'sd256, 32'sd256};   // continuity, gapped input
        vt[2] = '{1'b1, 1'b0, 1'b0, 32'sd256, 32'sd0};     // impulse
        vt[3] = '{1'b1, 1'b0, 1'b1, -32'sd256, -32'sd256}; // negative step, pulses while busy
        vt[4] = '{1'b0, 1'b0, 1'b0, -32'sd256, -32'sd256}; // steady -1.0
        vt[5] = '{1'b1, 1'b1, 1'b0, 32'sd1, 32'sd1};       // tiny positive floors to 0
        vt[6] = '{1'b1, 1'b0, 1'b0, -32'sd1, -32'sd1};     // tiny negative floors to -1
        vt[7] = '{1'b1, 1'b0, 1'b0, 32'sh7FFF_FFFF, 32'sh7FFF_FFFF};
        for (int k = 0; k < AS; k++) begin
            exp_tab[0][k] = 16 * ramp(k);
            exp_tab[1][k] = 256;
            exp_tab[2][k] = (k < 8) ? 64'sd16 : 64'sd0;
            exp_tab[3][k] = -16 * ramp(k);
            exp_tab[4][k] = -256;
            exp_tab[5][k] = 0;
            exp_tab[6][k] = -ramp(k);
            exp_tab[7][k] = 64'sd134217727 * ramp(k);
        end

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst wait", WAIT, 0);
        chk("rst ov", output_valid, 0);
        chk("rst y0", dout[0], 0);
        chk("rst y15", dout[AS-1], 0);

        for (int n = 0; n < NV; n++) run_frame(n);

        // Reset during COMPUTE must abort the frame with no output_valid
        for (int i = 0; i < 32; i++) begin
            new_sample = 32'sd256;
            valid_in   = 1'b1;
            @(negedge clk);
        end
        valid_in = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst wait", WAIT, 0);
        chk("midrst y0", dout[0], 0);
        ov_hits = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (output_valid) ov_hits++;
        end
        chk("midrst no ov", ov_hits, 0);
        vt[0].do_reset = 1'b0;
        run_frame(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
